// File: rtl/temp_avg_accum.sv
// Window averager for temperature samples: accumulates NUM_SAMPLES en_sum strobes, then divides by NUM_SAMPLES
// with a restoring shift/subtract divider. Define TEMP_AVG_ROUND_EN for round-half-up instead of truncation.
//
//   state  | meaning
//   ACCUM  | collecting samples into acc
//   DIVIDE | one quotient bit per cycle, MSB first, ACC_W cycles
//   DONE   | publish quotient on avg, pulse avg_valid
module temp_avg_accum #(
   parameter int DATA_W      = 8,
   parameter int NUM_SAMPLES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_sum,
   input  logic              rst_sum,
   input  logic [DATA_W-1:0] temp_in,
   output logic [DATA_W-1:0] avg,
   output logic              avg_valid,
   output logic              busy,
   output logic              overrun
);

   localparam int ACC_W = DATA_W + $clog2(NUM_SAMPLES);
   localparam int CNT_W = $clog2(NUM_SAMPLES);
   localparam int REM_W = $clog2(NUM_SAMPLES);
   localparam int IDX_W = $clog2(ACC_W);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(ACC_W - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [REM_W:0]   DIVISOR  = (REM_W + 1)'(NUM_SAMPLES);
`ifdef TEMP_AVG_ROUND_EN
   localparam logic [ACC_W-1:0] ROUND_ADD = ACC_W'(NUM_SAMPLES >> 1);
`else
   localparam logic [ACC_W-1:0] ROUND_ADD = '0;
`endif

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_DIVIDE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]  count;
   logic [ACC_W-1:0]  dividend;
   logic [REM_W-1:0]  rem;
   logic [DATA_W-1:0] quot;
   logic [IDX_W-1:0]  bit_idx;

   logic [ACC_W-1:0]  temp_ext;
   logic              last_sample;
   logic [REM_W:0]    rem_shift;
   logic              q_bit;
   logic [REM_W-1:0]  rem_nxt;

   assign temp_ext    = {{(ACC_W - DATA_W){1'b0}}, temp_in};
   assign last_sample = en_sum && (count == CNT_LAST);

   // Remainder stays below NUM_SAMPLES, so REM_W bits hold it and one extra bit covers the shift.
   always_comb begin
      rem_shift = {rem, dividend[bit_idx]};
      q_bit     = (rem_shift >= DIVISOR);
      rem_nxt   = rem_shift[REM_W-1:0];
      if (q_bit) begin
         rem_nxt = REM_W'(rem_shift - DIVISOR);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (rst_sum) begin
         state_nxt = ST_ACCUM;
      end else begin
         case (state)
            ST_ACCUM:  if (last_sample) state_nxt = ST_DIVIDE;
            ST_DIVIDE: if (bit_idx == '0) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_ACCUM;
            default:   state_nxt = ST_ACCUM;
         endcase
      end
   end

   always_comb begin
      busy = (state == ST_DIVIDE) || (state == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         count     <= '0;
         dividend  <= '0;
         rem       <= '0;
         quot      <= '0;
         bit_idx   <= '0;
         avg       <= '0;
         avg_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (rst_sum) begin
         acc       <= '0;
         count     <= '0;
         overrun   <= 1'b0;
         avg_valid <= 1'b0;
      end else begin
         avg_valid <= 1'b0;
         case (state)
            ST_ACCUM: begin
               if (last_sample) begin
                  dividend <= acc + temp_ext + ROUND_ADD;
                  rem      <= '0;
                  quot     <= '0;
                  bit_idx  <= IDX_TOP;
                  count    <= '0;
                  acc      <= acc + temp_ext;
               end else if (en_sum) begin
                  acc   <= acc + temp_ext;
                  count <= count + CNT_ONE;
               end
            end
            ST_DIVIDE: begin
               // Upper quotient bits are zero by construction, so they shift out harmlessly.
               rem     <= rem_nxt;
               quot    <= {quot[DATA_W-2:0], q_bit};
               bit_idx <= bit_idx - IDX_ONE;
               if (en_sum) overrun <= 1'b1;
            end
            ST_DONE: begin
               avg       <= quot;
               avg_valid <= 1'b1;
               acc       <= '0;
               if (en_sum) overrun <= 1'b1;
            end
            default: begin
               acc <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_temp_avg_accum.sv
// Scoreboard bench for temp_avg_accum, DATA_W=8, NUM_SAMPLES=5; expectations follow TEMP_AVG_ROUND_EN.
module tb_temp_avg_accum;

   localparam int DATA_W = 8;
   localparam int NS     = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              en_sum;
   logic              rst_sum;
   logic [DATA_W-1:0] temp_in;
   logic [DATA_W-1:0] avg;
   logic              avg_valid;
   logic              busy;
   logic              overrun;

   int                n_tests = 0;
   int                n_fail  = 0;
   int                exp_q[$];

   temp_avg_accum #(.DATA_W(DATA_W), .NUM_SAMPLES(NS)) dut (
      .clk       (clk),
      .rst       (rst),
      .en_sum    (en_sum),
      .rst_sum   (rst_sum),
      .temp_in   (temp_in),
      .avg       (avg),
      .avg_valid (avg_valid),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model_avg(input int sum);
`ifdef TEMP_AVG_ROUND_EN
      return (sum + NS / 2) / NS;
`else
      return sum / NS;
`endif
   endfunction

   // Every published average must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && avg_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            chk("avg", int'(avg), exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v);
      en_sum  = 1'b1;
      temp_in = DATA_W'(v);
      tick();
      en_sum  = 1'b0;
   endtask

   task automatic send_window(input int a, input int b, input int c, input int d, input int e);
      send(a); send(b); send(c); send(d);
      exp_q.push_back(model_avg(a + b + c + d + e));
      send(e);
   endtask

   task automatic wait_valid();
      bit got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (avg_valid) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("valid_timeout", 0, 1);
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst     = 1'b1;
      en_sum  = 1'b0;
      rst_sum = 1'b0;
      temp_in = '0;
      idle(3);
      chk("rst_avg", int'(avg), 0);
      chk("rst_valid", int'(avg_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);
      rst = 1'b0;
      idle(2);

      // Latency and busy window around the first average.
      send_window(20, 21, 22, 23, 24);
      for (int k = 0; k < 12; k++) begin
         chk("lat_busy", int'(busy), 1);
         chk("lat_valid_early", int'(avg_valid), 0);
         tick();
      end
      chk("lat_valid", int'(avg_valid), 1);
      chk("lat_busy_end", int'(busy), 0);
      chk("lat_avg", int'(avg), 22);
      tick();
      chk("lat_valid_pulse", int'(avg_valid), 0);

      send_window(20, 20, 20, 20, 23);
      wait_valid();

      send_window(255, 255, 255, 255, 255);
      wait_valid();
      chk("max_avg", int'(avg), 255);

      // Abort on the third DIVIDE cycle.
      send_window(20, 21, 22, 23, 24);
      wait_valid();
      send(1); send(2); send(3); send(4); send(5);
      idle(2);
      rst_sum = 1'b1;
      tick();
      rst_sum = 1'b0;
      idle(20);
      chk("abort_avg", int'(avg), 22);
      chk("abort_busy", int'(busy), 0);
      send_window(10, 10, 10, 10, 10);
      wait_valid();
      chk("post_abort_avg", int'(avg), 10);

      // Overrun: sample during DIVIDE is dropped and does not count toward the next window.
      chk("ovr_clear", int'(overrun), 0);
      send_window(30, 30, 30, 30, 30);
      idle(3);
      send(200);
      chk("ovr_set", int'(overrun), 1);
      wait_valid();
      chk("ovr_result", int'(avg), 30);
      send(40); send(40); send(40); send(40);
      idle(20);
      chk("ovr_partial_avg", int'(avg), 30);
      exp_q.push_back(model_avg(200));
      send(40);
      wait_valid();
      chk("ovr_sticky", int'(overrun), 1);
      rst_sum = 1'b1;
      tick();
      rst_sum = 1'b0;
      chk("ovr_rst_sum", int'(overrun), 0);

      // rst_sum beats en_sum in the same cycle.
      send(100); send(100);
      en_sum  = 1'b1;
      rst_sum = 1'b1;
      temp_in = 8'd100;
      tick();
      en_sum  = 1'b0;
      rst_sum = 1'b0;
      send_window(7, 8, 9, 10, 11);
      wait_valid();
      chk("clr_avg", int'(avg), 9);

      idle(5);
      chk("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
